wb_commit_queue: RTL and testbench

- Write-back side of the ID register file's write port: collects results from the EX and MEM stages and drives `reg_write`/`data_write` into `id_reg_file`, at most one register write per cycle.
- Buffers results in a small FIFO so that simultaneous EX and MEM completions are never lost.
- Guarantees every queued write appears as a distinct event on the port, so each `modified[]` decrement fires exactly once.

---
 rtl/wb_commit_queue_pkg.sv | 19 +
 rtl/wbq_fifo.sv | 51 +++++
 rtl/wb_commit_queue.sv | 102 ++++++++++
 tb/tb_wb_commit_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_queue_pkg.sv
// Shared widths and entry layout for the write-back commit queue.
package wb_commit_queue_pkg;

    localparam int REG_NUM      = 5;   // register index width
    localparam int COMMON_WIDTH = 32;  // datapath width
    localparam int WBQ_DEPTH    = 4;   // default queue depth

    // One pending register-file write.
    typedef struct packed {
        logic [REG_NUM-1:0]      rd;
        logic [COMMON_WIDTH-1:0] data;
    } wbq_entry_t;

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int wbq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wbq_fifo.sv
// Dual-write, single-read circular buffer.
// wr1 is only meaningful together with wr0; it lands one slot after wr0.
module wbq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr0_en,
    input  logic [W-1:0]     wr0_data,
    input  logic             wr1_en,
    input  logic [W-1:0]     wr1_data,
    input  logic             rd_en,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] tail_nxt1;
    logic [1:0]       n_wr;

    // Power-of-two depth, so pointer arithmetic wraps by truncation.
    assign tail_nxt1 = tail_ptr + PTR_W'(1);
    assign n_wr      = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign head      = mem[head_ptr];

    // Storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[tail_ptr]  <= wr0_data;
        if (wr1_en) mem[tail_nxt1] <= wr1_data;
    end

    // Pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            tail_ptr <= tail_ptr + PTR_W'(n_wr);
            if (rd_en) head_ptr <= head_ptr + PTR_W'(1);
            count    <= count + CNT_W'(n_wr) - CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back commit queue: merges EX and MEM results into the single
// register-file write port, one write per cycle, strictly in order.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int REG_W  = REG_NUM,
    parameter int DATA_W = COMMON_WIDTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_valid,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wbq_stall,
    output logic [CNT_W-1:0]  wbq_count,
    output logic [REG_W-1:0]  reg_write,
    output logic [DATA_W-1:0] data_write
);

    localparam int ENT_W = REG_W + DATA_W;

    logic              acc_ex;
    logic              acc_mem;
    logic              wr0_en;
    logic              wr1_en;
    logic [ENT_W-1:0]  wr0_data;
    logic [ENT_W-1:0]  wr1_data;
    logic [ENT_W-1:0]  head;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_data;
    logic              dup;
    logic              pop;
    logic [REG_W-1:0]  last_rd;
    logic [DATA_W-1:0] last_data;

    // Two free slots are always kept so a dual accept can never overflow.
    assign wbq_stall = (CNT_W'(DEPTH) - wbq_count) < CNT_W'(2);

    // r0 is hardwired, so its results never occupy a slot.
    assign acc_mem = mem_valid && (mem_rd != '0) && !wbq_stall;
    assign acc_ex  = ex_valid  && (ex_rd  != '0) && !wbq_stall;

    // Compact accepted results into wr0/wr1; MEM is older, so it goes first.
    always_comb begin
        wr0_en   = acc_mem || acc_ex;
        wr1_en   = acc_mem && acc_ex;
        wr0_data = acc_mem ? {mem_rd, mem_data} : {ex_rd, ex_data};
        wr1_data = {ex_rd, ex_data};
    end

    wbq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (pop),
        .head     (head),
        .count    (wbq_count)
    );

    assign head_rd   = head[ENT_W-1 -: REG_W];
    assign head_data = head[DATA_W-1:0];

    // The register file only reacts to port changes: an identical write right
    // after the previous one would be invisible, so insert a one-cycle bubble.
    assign dup = (reg_write != '0) && (head_rd == last_rd) && (head_data == last_data);
    assign pop = (wbq_count != '0) && !dup;

    // Present the head for exactly one cycle; data holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= '0;
            data_write <= '0;
            last_rd    <= '0;
            last_data  <= '0;
        end else if (pop) begin
            reg_write  <= head_rd;
            data_write <= head_data;
            last_rd    <= head_rd;
            last_data  <= head_data;
        end else begin
            reg_write  <= '0;
        end
    end

    // Upstream must not offer results while stalled; such results are dropped.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(wbq_stall && (ex_valid || mem_valid)));
    end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench: directed steps plus randomized traffic against a
// queue-based reference model of the write-back port.
module tb_wb_commit_queue;
    import wb_commit_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_valid;
    logic [4:0]  ex_rd, mem_rd;
    logic [31:0] ex_data, mem_data;
    logic        wbq_stall;
    logic [2:0]  wbq_count;
    logic [4:0]  reg_write;
    logic [31:0] data_write;

    always #5 clk = ~clk;

    wb_commit_queue #(.DEPTH(DEPTH), .REG_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wbq_stall  (wbq_stall),
        .wbq_count  (wbq_count),
        .reg_write  (reg_write),
        .data_write (data_write)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int w7     = 0;

    // Reference model: pending writes, last port values, last write issued.
    wbq_entry_t  q[$];
    logic [4:0]  m_rw;
    logic [31:0] m_dw;
    wbq_entry_t  m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rw   = '0;
        m_dw   = '0;
        m_last = '0;
    endtask

    function automatic bit m_stall();
        return (DEPTH - q.size()) < 2;
    endfunction

    // One clock edge of the port rules: issue the oldest pending write unless
    // it would repeat the write issued on the immediately preceding cycle.
    task automatic model_edge(input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                              input bit ev, input logic [4:0] erd, input logic [31:0] ed);
        bit st;
        bit pres;
        st   = m_stall();
        pres = (q.size() > 0) && !((m_rw != 0) && (q[0] == m_last));
        if (pres) begin
            m_last = q[0];
            m_rw   = q[0].rd;
            m_dw   = q[0].data;
            void'(q.pop_front());
        end else begin
            m_rw = '0;
        end
        if (!st && mv && mrd != 0) q.push_back('{rd: mrd, data: md});
        if (!st && ev && erd != 0) q.push_back('{rd: erd, data: ed});
    endtask

    task automatic step(input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                        input bit ev, input logic [4:0] erd, input logic [31:0] ed);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        ex_valid  = ev; ex_rd  = erd; ex_data  = ed;
        chk("stall_pre", wbq_stall, m_stall());
        @(posedge clk);
        model_edge(mv, mrd, md, ev, erd, ed);
        #1;
        chk("reg_write", reg_write, m_rw);
        chk("data_write", data_write, m_dw);
        chk("count", wbq_count, q.size());
        chk("stall", wbq_stall, m_stall());
        if (reg_write == 5'd7) w7++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        model_reset();
        #3;
        chk("rst_rw", reg_write, 0);
        chk("rst_dw", data_write, 0);
        chk("rst_count", wbq_count, 0);
        chk("rst_stall", wbq_stall, 0);
        #4 rst = 1'b0;

        // Single write: accepted at edge 1, presented after edge 2, gone after 3.
        step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        chk("t2_no_bypass", reg_write, 0);
        idle();
        chk("t2_rw", reg_write, 5);
        chk("t2_dw", data_write, 32'hDEADBEEF);
        idle();
        chk("t2_rw_clear", reg_write, 0);
        chk("t2_dw_hold", data_write, 32'hDEADBEEF);

        // Dual write to the same rd: MEM retires first.
        step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        chk("t3_count", wbq_count, 2);
        idle();
        chk("t3_first_rw", reg_write, 3);
        chk("t3_first_dw", data_write, 32'h11);
        idle();
        chk("t3_second_rw", reg_write, 3);
        chk("t3_final_dw", data_write, 32'h22);
        idle();

        // Identical consecutive writes: 7, bubble, 7.
        w7 = 0;
        step(0, 0, 0, 1, 5'd7, 32'h5);
        step(0, 0, 0, 1, 5'd7, 32'h5);
        chk("t4_a", reg_write, 7);
        idle();
        chk("t4_bubble", reg_write, 0);
        idle();
        chk("t4_b", reg_write, 7);
        idle();
        chk("t4_writes", w7, 2);

        // rd == 0 is discarded; stall at count 3, released at 2.
        step(0, 0, 0, 1, 5'd0, 32'hABCD);
        chk("t5_rd0_count", wbq_count, 0);
        step(1, 5'd9, 32'hA, 1, 5'd10, 32'hB);
        step(1, 5'd11, 32'hC, 1, 5'd12, 32'hD);
        chk("t5_full_count", wbq_count, 3);
        chk("t5_stall_hi", wbq_stall, 1);
        idle();
        chk("t5_drain_count", wbq_count, 2);
        chk("t5_stall_lo", wbq_stall, 0);
        repeat (3) idle();

        // Reset in the middle of a drain.
        step(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        step(0, 0, 0, 1, 5'd13, 32'h3);
        chk("t1_first_pres", reg_write, 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_rw", reg_write, 0);
        chk("t1_rst_count", wbq_count, 0);
        chk("t1_rst_dw", data_write, 0);
        model_reset();
        ex_valid = 0; mem_valid = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t1_held_rw", reg_write, 0);
        repeat (3) idle();
        chk("t1_after_rw", reg_write, 0);

        // Randomized traffic with stall honoured; small rd/data ranges force
        // frequent identical back-to-back writes and pointer wraps.
        for (int i = 0; i < 60; i++) begin
            bit st;
            bit mv, ev;
            st = m_stall();
            mv = !st && ($urandom_range(0, 1) == 1);
            ev = !st && ($urandom_range(0, 2) != 0);
            step(mv, 5'($urandom_range(0, 3)), 32'($urandom_range(0, 2)),
                 ev, 5'($urandom_range(0, 3)), 32'($urandom_range(0, 2)));
        end
        repeat (10) idle();
        chk("t6_drained", wbq_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
